// File: rtl/alu_resp_checker.sv
// alu_resp_checker
//   Response checker for the 8-bit ALU. Each accepted sample {A,B,ALU_Sel,ALU_Out}
//   is registered (S1), the golden result is computed and registered alongside it
//   (S2), and the pass/fail/skip tallies update on the following edge. The first
//   mismatch is captured in fail_info.
//
//   Optional feature: define ALU_CHK_HALT_ON_FAIL_EN to stop checking on the first
//   mismatch (RUN -> HALT, done=1). Without it the checker keeps running.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   start, stop       control pulses (start wins over stop)
//   smp_valid         A/B/ALU_Sel/ALU_Out valid this cycle
//   A, B, ALU_Sel     operation applied to the alu
//   ALU_Out           alu result for that operation
//   busy, done        FSM in RUN / in DONE (or HALT)
//   pass_cnt, fail_cnt, skip_cnt   saturating tallies
//   fail_seen, fail_info           sticky first-mismatch capture
//                                  {ALU_Sel, A, B, got, exp}
module alu_resp_checker #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             smp_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  input  logic [WIDTH-1:0] ALU_Out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic             fail_seen,
  output logic [35:0]      fail_info
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
`ifdef ALU_CHK_HALT_ON_FAIL_EN
    , ST_HALT
`endif
  } state_t;

  state_t state, state_nxt;

  // Stage 1: registered sample
  logic             s1_vld;
  logic [WIDTH-1:0] s1_a, s1_b, s1_out;
  logic [3:0]       s1_sel;

  // Stage 2: registered sample plus golden result and verdict
  logic             s2_vld;
  logic [WIDTH-1:0] s2_a, s2_b, s2_out, s2_gold;
  logic [3:0]       s2_sel;
  logic             s2_skip;
  logic             s2_bad;

  logic [WIDTH-1:0] gold;
  logic             skip;
  logic             bad;
  logic             accept;
  logic             fail_hit;
  logic             halt_hit;

  // Golden model, all results modulo 2^WIDTH
  always_comb begin
    gold = '0;
    case (s1_sel)
      4'h0: gold = s1_a + s1_b;
      4'h1: gold = s1_a - s1_b;
      4'h2: gold = s1_a * s1_b;
      4'h3: gold = (s1_b == '0) ? '0 : s1_a / s1_b;
      4'h4: gold = s1_a << 1;
      4'h5: gold = s1_a >> 1;
      4'h6: gold = {s1_a[WIDTH-2:0], s1_a[WIDTH-1]};
      4'h7: gold = {s1_a[0], s1_a[WIDTH-1:1]};
      4'h8: gold = s1_a & s1_b;
      4'h9: gold = s1_a | s1_b;
      4'hA: gold = s1_a ^ s1_b;
      4'hB: gold = ~(s1_a | s1_b);
      4'hC: gold = ~(s1_a & s1_b);
      4'hD: gold = ~(s1_a ^ s1_b);
      4'hE: gold[0] = (s1_a > s1_b);
      4'hF: gold[0] = (s1_a == s1_b);
      default: gold = '0;
    endcase
  end

  always_comb begin
    skip     = (s1_sel == 4'h3) && (s1_b == '0);
    // Any X/Z bit in the alu result is treated as a mismatch
    bad      = $isunknown(s1_out) || (s1_out != gold);
    // A sample arriving on the stop (or start) cycle is dropped
    accept   = smp_valid && busy && !stop && !start;
    fail_hit = s2_vld && !s2_skip && s2_bad;
`ifdef ALU_CHK_HALT_ON_FAIL_EN
    halt_hit = fail_hit;
`else
    halt_hit = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (start)         state_nxt = ST_RUN;
`ifdef ALU_CHK_HALT_ON_FAIL_EN
        else if (halt_hit) state_nxt = ST_HALT;
`endif
        else if (stop)     state_nxt = ST_DONE;
      end
      ST_DONE: if (start) state_nxt = ST_RUN;
`ifdef ALU_CHK_HALT_ON_FAIL_EN
      ST_HALT: if (start) state_nxt = ST_RUN;
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      s1_vld    <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_sel    <= '0;
      s1_out    <= '0;
      s2_vld    <= 1'b0;
      s2_a      <= '0;
      s2_b      <= '0;
      s2_sel    <= '0;
      s2_out    <= '0;
      s2_gold   <= '0;
      s2_skip   <= 1'b0;
      s2_bad    <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      skip_cnt  <= '0;
      fail_seen <= 1'b0;
      fail_info <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
`ifdef ALU_CHK_HALT_ON_FAIL_EN
      done  <= (state_nxt == ST_DONE) || (state_nxt == ST_HALT);
`else
      done  <= (state_nxt == ST_DONE);
`endif

      s1_vld <= accept;
      if (accept) begin
        s1_a   <= A;
        s1_b   <= B;
        s1_sel <= ALU_Sel;
        s1_out <= ALU_Out;
      end

      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_a    <= s1_a;
        s2_b    <= s1_b;
        s2_sel  <= s1_sel;
        s2_out  <= s1_out;
        s2_gold <= gold;
        s2_skip <= skip;
        s2_bad  <= bad;
      end

      if (s2_vld) begin
        if (s2_skip) begin
          if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
        end else if (s2_bad) begin
          if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
          if (!fail_seen) begin
            fail_seen <= 1'b1;
            fail_info <= {s2_sel, s2_a, s2_b, s2_out, s2_gold};
          end
        end else begin
          if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        end
      end

      // Halting discards everything still in flight behind the failing sample
      if (halt_hit) begin
        s1_vld <= 1'b0;
        s2_vld <= 1'b0;
      end

      // start overrides every update above on the same edge
      if (start) begin
        s1_vld    <= 1'b0;
        s2_vld    <= 1'b0;
        pass_cnt  <= '0;
        fail_cnt  <= '0;
        skip_cnt  <= '0;
        fail_seen <= 1'b0;
        fail_info <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_resp_checker.sv
// tb_alu_resp_checker
//   Directed bench for alu_resp_checker. A second instance with CNT_W=2 shares
//   the same stimulus to observe counter saturation.
module tb_alu_resp_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, smp_valid;
  logic [7:0]  A, B, ALU_Out;
  logic [3:0]  ALU_Sel;
  logic        busy, done, fail_seen;
  logic [15:0] pass_cnt, fail_cnt, skip_cnt;
  logic [35:0] fail_info;

  logic        sat_busy, sat_done, sat_fail_seen;
  logic [1:0]  sat_pass, sat_fail, sat_skip;
  logic [35:0] sat_info;

  int unsigned tests  = 0;
  int unsigned failed = 0;

  always #5 clk = ~clk;

  alu_resp_checker #(.CNT_W(16), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .smp_valid(smp_valid),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .skip_cnt(skip_cnt), .fail_seen(fail_seen), .fail_info(fail_info)
  );

  alu_resp_checker #(.CNT_W(2), .WIDTH(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .smp_valid(smp_valid),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .ALU_Out(ALU_Out),
    .busy(sat_busy), .done(sat_done), .pass_cnt(sat_pass), .fail_cnt(sat_fail),
    .skip_cnt(sat_skip), .fail_seen(sat_fail_seen), .fail_info(sat_info)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic st, input logic sp, input logic v,
                     input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] s, input logic [7:0] o);
    @(negedge clk);
    start = st; stop = sp; smp_valid = v;
    A = a; B = b; ALU_Sel = s; ALU_Out = o;
  endtask

  task automatic smp(input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] s, input logic [7:0] o);
    cyc(1'b0, 1'b0, 1'b1, a, b, s, o);
  endtask

  task automatic flush(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00);
  endtask

  logic [15:0] exp_pass_after_goods;
  logic [15:0] exp_fail_after_second;
  logic        exp_busy_after_fail;

  initial begin
`ifdef ALU_CHK_HALT_ON_FAIL_EN
    exp_pass_after_goods  = 16'd12;
    exp_fail_after_second = 16'd1;
    exp_busy_after_fail   = 1'b0;
`else
    exp_pass_after_goods  = 16'd15;
    exp_fail_after_second = 16'd2;
    exp_busy_after_fail   = 1'b1;
`endif
    rst_n = 1'b0;
    start = 0; stop = 0; smp_valid = 0; A = 0; B = 0; ALU_Sel = 0; ALU_Out = 0;
    repeat (2) @(negedge clk);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_fail", fail_cnt, 0);
    chk("rst_skip", skip_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_seen", fail_seen, 0);
    chk("rst_info", fail_info, 0);
    rst_n = 1'b1;

    // Samples in IDLE are ignored
    smp(8'h01, 8'h01, 4'h0, 8'h02);
    flush(3);
    chk("idle_pass", pass_cnt, 0);

    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00);
    flush(1);
    chk("start_busy", busy, 1);

    // Sel 1..5 with A=0x0A, B=0x02
    smp(8'h0A, 8'h02, 4'h1, 8'h08);
    smp(8'h0A, 8'h02, 4'h2, 8'h14);
    smp(8'h0A, 8'h02, 4'h3, 8'h05);
    smp(8'h0A, 8'h02, 4'h4, 8'h14);
    smp(8'h0A, 8'h02, 4'h5, 8'h05);
    // Latency: two edges after the last sample edge the tally is not yet final
    flush(2);
    chk("lat_pass", pass_cnt, 4);
    flush(1);
    chk("t1_pass", pass_cnt, 5);
    chk("t1_fail", fail_cnt, 0);
    chk("sat_pass", sat_pass, 3);

    // 8-bit wrap on add
    smp(8'hFF, 8'h01, 4'h0, 8'h00);
    flush(3);
    chk("wrap_pass", pass_cnt, 6);

    // Divide by zero is skipped
    smp(8'h0A, 8'h00, 4'h3, 8'h00);
    flush(3);
    chk("div0_skip", skip_cnt, 1);
    chk("div0_pass", pass_cnt, 6);
    chk("div0_fail", fail_cnt, 0);

    // Remaining opcodes, all correct
    smp(8'h81, 8'h00, 4'h6, 8'h03);
    smp(8'h81, 8'h00, 4'h7, 8'hC0);
    smp(8'hF0, 8'h0F, 4'hB, 8'h00);
    smp(8'h05, 8'h03, 4'hE, 8'h01);
    smp(8'h05, 8'h05, 4'hF, 8'h01);
    smp(8'h10, 8'h11, 4'h2, 8'h10);
    flush(3);
    chk("ops_pass", pass_cnt, 12);
    chk("ops_fail", fail_cnt, 0);

    // First mismatch, then three good samples back to back
    smp(8'hFF, 8'h01, 4'h0, 8'h01);
    smp(8'h0A, 8'h05, 4'h9, 8'h0F);
    smp(8'hFF, 8'h0F, 4'hA, 8'hF0);
    smp(8'hFF, 8'h0F, 4'hC, 8'hF0);
    flush(3);
    chk("fail1_cnt", fail_cnt, 1);
    chk("fail1_seen", fail_seen, 1);
    chk("fail1_info", fail_info, 36'h0FF010100);
    chk("goods_pass", pass_cnt, exp_pass_after_goods);
    chk("goods_busy", busy, exp_busy_after_fail);
    chk("goods_done", done, !exp_busy_after_fail);

    // Second mismatch leaves the capture alone
    smp(8'hF0, 8'h3C, 4'h8, 8'h31);
    flush(3);
    chk("fail2_cnt", fail_cnt, exp_fail_after_second);
    chk("fail2_info", fail_info, 36'h0FF010100);

    // stop -> DONE, samples ignored
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00);
    flush(1);
    chk("stop_done", done, 1);
    chk("stop_busy", busy, 0);
    smp(8'h01, 8'h02, 4'h0, 8'h03);
    smp(8'h01, 8'h02, 4'h0, 8'h00);
    flush(3);
    chk("done_pass", pass_cnt, exp_pass_after_goods);
    chk("done_fail", fail_cnt, exp_fail_after_second);

    // start clears everything and re-enters RUN
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00);
    flush(1);
    chk("restart_pass", pass_cnt, 0);
    chk("restart_fail", fail_cnt, 0);
    chk("restart_skip", skip_cnt, 0);
    chk("restart_seen", fail_seen, 0);
    chk("restart_info", fail_info, 0);
    chk("restart_busy", busy, 1);

    // In-flight sample retires after stop; sample on stop's cycle is dropped
    smp(8'h03, 8'h04, 4'h0, 8'h07);
    cyc(1'b0, 1'b1, 1'b1, 8'h03, 8'h04, 4'h0, 8'h07);
    flush(3);
    chk("stop_inflight", pass_cnt, 1);
    chk("stop_done2", done, 1);

    // start and stop together: start wins
    cyc(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 8'h00);
    flush(1);
    chk("startstop_busy", busy, 1);
    chk("startstop_pass", pass_cnt, 0);

    // Reset mid-RUN drops in-flight samples
    smp(8'h02, 8'h02, 4'h0, 8'h04);
    @(negedge clk);
    smp_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_pass", pass_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    flush(3);
    chk("postrst_pass", pass_cnt, 0);
    chk("postrst_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
